// File: rtl/modexp_pkg.sv
// Shared FSM state encoding and datapath op codes for the modular-exponentiation sequencer.
package modexp_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    ISSUE_SQ,
    WAIT_SQ,
    ISSUE_SQMOD,
    WAIT_SQMOD,
    ISSUE_MUL,
    WAIT_MUL,
    ISSUE_MULMOD,
    WAIT_MULMOD,
    NEXT,
    DONE
  } modexp_state_e;

  localparam logic [1:0] OP_SQUARE   = 2'd0;
  localparam logic [1:0] OP_MULTIPLY = 2'd1;
  localparam logic [1:0] OP_MODULO   = 2'd2;

endpackage

// File: rtl/modexp_sequencer_if.sv
// Requester/datapath-facing signal bundle of the modexp sequencer.
// master = requester + datapath side, slave = the sequencer itself.
interface modexp_sequencer_if #(
  parameter int EXP_W = 16
);
  localparam int IDX_W = $clog2(EXP_W);

  logic             start;
  logic [EXP_W-1:0] exponent;
  logic             op_done;
  logic             initialize;
  logic             op_start;
  logic [1:0]       op_code;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] bit_index;

  modport master (
    output start, exponent, op_done,
    input  initialize, op_start, op_code, busy, done, bit_index
  );

  modport slave (
    input  start, exponent, op_done,
    output initialize, op_start, op_code, busy, done, bit_index
  );

endinterface

// File: rtl/modexp_lead_one.sv
// Index of the most-significant set bit of the exponent (0 when the exponent is 0).
// Only built when MODEXP_SKIP_LEADING_ZEROS_EN is defined.
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
module modexp_lead_one #(
  parameter int EXP_W = 16,
  localparam int IDX_W = $clog2(EXP_W)
) (
  input  logic [EXP_W-1:0] exp_i,
  output logic [IDX_W-1:0] idx_o
);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < EXP_W; i++) begin
      if (exp_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule
`endif

// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply sequencer driving an external modular datapath.
// Optional MODEXP_SKIP_LEADING_ZEROS_EN starts at the exponent's most-significant 1.
module modexp_sequencer
  import modexp_pkg::*;
#(
  parameter int EXP_W = 16
) (
  input logic               clk,
  input logic               rst,
  modexp_sequencer_if.slave bus
);

  localparam int IDX_W = $clog2(EXP_W);

  modexp_state_e    state_q;
  logic [EXP_W-1:0] exp_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic [IDX_W-1:0] start_idx_d;
  logic             initialize_q;
  logic             op_start_q;
  logic [1:0]       op_code_q;
  logic             busy_q;
  logic             done_q;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  modexp_lead_one #(
    .EXP_W (EXP_W)
  ) u_lead_one (
    .exp_i (bus.exponent),
    .idx_o (start_idx_d)
  );
`else
  assign start_idx_d = IDX_W'(EXP_W - 1);
`endif

  // Operand register: captured only on an accepted start, so later starts cannot disturb a run.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.start) exp_q <= bus.exponent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_idx_q    <= '0;
      initialize_q <= 1'b0;
      op_start_q   <= 1'b0;
      op_code_q    <= OP_SQUARE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      initialize_q <= 1'b0;
      op_start_q   <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q      <= INIT;
            bit_idx_q    <= start_idx_d;
            initialize_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        INIT: begin
          if (exp_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= ISSUE_SQ;
            op_start_q <= 1'b1;
            op_code_q  <= OP_SQUARE;
          end
        end
        ISSUE_SQ: state_q <= WAIT_SQ;
        WAIT_SQ: begin
          if (bus.op_done) begin
            state_q    <= ISSUE_SQMOD;
            op_start_q <= 1'b1;
            op_code_q  <= OP_MODULO;
          end
        end
        ISSUE_SQMOD: state_q <= WAIT_SQMOD;
        WAIT_SQMOD: begin
          if (bus.op_done) begin
            if (exp_q[bit_idx_q]) begin
              state_q    <= ISSUE_MUL;
              op_start_q <= 1'b1;
              op_code_q  <= OP_MULTIPLY;
            end else begin
              state_q <= NEXT;
            end
          end
        end
        ISSUE_MUL: state_q <= WAIT_MUL;
        WAIT_MUL: begin
          if (bus.op_done) begin
            state_q    <= ISSUE_MULMOD;
            op_start_q <= 1'b1;
            op_code_q  <= OP_MODULO;
          end
        end
        ISSUE_MULMOD: state_q <= WAIT_MULMOD;
        WAIT_MULMOD: begin
          if (bus.op_done) state_q <= NEXT;
        end
        NEXT: begin
          if (bit_idx_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= ISSUE_SQ;
            bit_idx_q  <= bit_idx_q - 1'b1;
            op_start_q <= 1'b1;
            op_code_q  <= OP_SQUARE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.initialize = initialize_q;
  assign bus.op_start   = op_start_q;
  assign bus.op_code    = op_code_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.bit_index  = bit_idx_q;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Scoreboard bench for modexp_sequencer (EXP_W=4); honours MODEXP_SKIP_LEADING_ZEROS_EN.
module tb_modexp_sequencer;
  import modexp_pkg::*;

  localparam int EXP_W = 4;
  localparam int IDX_W = $clog2(EXP_W);

  typedef struct packed {
    logic [1:0]       op;
    logic [IDX_W-1:0] idx;
  } exp_op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  modexp_sequencer_if #(.EXP_W(EXP_W)) bus ();

  modexp_sequencer #(.EXP_W(EXP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_op_t sb_q[$];
  exp_op_t mon_e;
  int      checks   = 0;
  int      errors   = 0;
  int      op_cnt   = 0;
  int      done_cnt = 0;
  bit      resp_en  = 1'b0;
  logic    pend     = 1'b0;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  // Datapath stand-in answers one cycle after each op_start; monitor pops the scoreboard.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (resp_en) begin
        bus.op_done = pend;
        pend        = bus.op_start;
      end else begin
        pend = 1'b0;
      end
      if (bus.done === 1'b1) done_cnt++;
      if (bus.op_start === 1'b1) begin
        op_cnt++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL op_unexpected: got op_code %0d bit_index %0d, required no op", bus.op_code, bus.bit_index);
        end else begin
          mon_e = sb_q.pop_front();
          if (bus.op_code !== mon_e.op || bus.bit_index !== mon_e.idx) begin
            errors++;
            $display("FAIL op_seq: got op_code %0d bit_index %0d, required op_code %0d bit_index %0d",
                     bus.op_code, bus.bit_index, mon_e.op, mon_e.idx);
          end
        end
      end
    end
  endtask

  task automatic push_model(input logic [EXP_W-1:0] e);
    int top;
    top = EXP_W - 1;
    if (SKIP) begin
      top = 0;
      for (int i = 0; i < EXP_W; i++) if (e[i]) top = i;
    end
    if (e != '0) begin
      for (int i = top; i >= 0; i--) begin
        sb_q.push_back('{op: OP_SQUARE, idx: IDX_W'(i)});
        sb_q.push_back('{op: OP_MODULO, idx: IDX_W'(i)});
        if (e[i]) begin
          sb_q.push_back('{op: OP_MULTIPLY, idx: IDX_W'(i)});
          sb_q.push_back('{op: OP_MODULO,   idx: IDX_W'(i)});
        end
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (bus.initialize !== 1'b0 || bus.op_start !== 1'b0 || bus.op_code !== 2'd0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bit_index !== '0) begin
      errors++;
      $display("FAIL %s: got init=%b op_start=%b op_code=%0d busy=%b done=%b bit_index=%0d, required all 0",
               name, bus.initialize, bus.op_start, bus.op_code, bus.busy, bus.done, bus.bit_index);
    end
  endtask

  task automatic wait_done(input int d0, input string name);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_timeout: got no done in %0d cycles, required one", name, n);
    end
  endtask

  task automatic test_reset();
    bus.start    = 1'b0;
    bus.exponent = '0;
    bus.op_done  = 1'b0;
    rst          = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_zero_exponent();
    int d0, o0;
    resp_en = 1'b0;
    d0 = done_cnt;
    o0 = op_cnt;
    bus.exponent = '0;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.initialize !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_init: got init=%b busy=%b, required 1 1", bus.initialize, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.initialize !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got done=%b init=%b, required 1 0", bus.done, bus.initialize);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || op_cnt != o0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL zero_end: got done=%b busy=%b ops=%0d dones=%0d, required 0 0 0 1",
               bus.done, bus.busy, op_cnt - o0, done_cnt - d0);
    end
  endtask

  task automatic test_run(input logic [EXP_W-1:0] e, input int req_ops, input int req_idx);
    int d0, o0;
    bus.op_done = 1'b0;
    resp_en     = 1'b1;
    push_model(e);
    d0 = done_cnt;
    o0 = op_cnt;
    bus.exponent = e;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.initialize !== 1'b1 || bus.busy !== 1'b1 || bus.bit_index !== IDX_W'(req_idx)) begin
      errors++;
      $display("FAIL run_init_%b: got init=%b busy=%b bit_index=%0d, required 1 1 %0d",
               e, bus.initialize, bus.busy, bus.bit_index, req_idx);
    end
    wait_done(d0, "run");
    repeat (2) @(negedge clk);
    checks++;
    if (op_cnt - o0 != req_ops || done_cnt - d0 != 1 || sb_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL run_end_%b: got ops=%0d dones=%0d left=%0d busy=%b, required %0d 1 0 0",
               e, op_cnt - o0, done_cnt - d0, sb_q.size(), bus.busy, req_ops);
    end
    resp_en = 1'b0;
  endtask

  task automatic test_start_ignored();
    int  d0, o0, n;
    bit  pulse_now, pulsed;
    bus.op_done = 1'b0;
    resp_en     = 1'b1;
    push_model(4'b1001);
    d0 = done_cnt;
    o0 = op_cnt;
    pulse_now = 1'b0;
    pulsed    = 1'b0;
    bus.exponent = 4'b1001;
    bus.start    = 1'b1;
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      if (pulse_now) begin
        bus.start    = 1'b1;
        bus.exponent = 4'b1111;
        pulse_now    = 1'b0;
        pulsed       = 1'b1;
      end else if (!pulsed && bus.op_start === 1'b1 && bus.op_code === OP_MULTIPLY) begin
        pulse_now = 1'b1;
      end
    end
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (!pulsed || done_cnt - d0 != 1 || op_cnt - o0 != 12 || sb_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored: got pulsed=%b dones=%0d ops=%0d left=%0d busy=%b, required 1 1 12 0 0",
               pulsed, done_cnt - d0, op_cnt - o0, sb_q.size(), bus.busy);
    end
    resp_en = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int  d0, o0, n;
    bit  found;
    bus.op_done = 1'b0;
    resp_en     = 1'b1;
    push_model(4'b0101);
    bus.exponent = 4'b0101;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.op_start === 1'b1 && bus.op_code === OP_MODULO) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_mid_reach: got no MODULO op in %0d cycles, required one", n);
    end
    @(negedge clk);
    resp_en     = 1'b0;
    bus.op_done = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    d0 = done_cnt;
    o0 = op_cnt;
    check_idle_outputs("rst_mid_after");
    bus.op_done = 1'b1;
    @(negedge clk);
    bus.op_done = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst_mid_late_op_done");
    checks++;
    if (op_cnt != o0 || done_cnt != d0) begin
      errors++;
      $display("FAIL rst_mid_activity: got ops=%0d dones=%0d, required 0 0", op_cnt - o0, done_cnt - d0);
    end
  endtask

  task automatic test_op_done_idle();
    resp_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.op_done = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.op_start !== 1'b0 || bus.done !== 1'b0 || bus.initialize !== 1'b0) begin
        errors++;
        $display("FAIL op_done_idle_%0d: got busy=%b op_start=%b done=%b init=%b, required 0 0 0 0",
                 i, bus.busy, bus.op_start, bus.done, bus.initialize);
      end
    end
    bus.op_done = 1'b0;
  endtask

  task automatic test_back_to_back();
    test_run(4'b1000, 10, 3);
    test_run(4'b1111, 16, 3);
    test_run(4'b0001, SKIP ? 4 : 10, SKIP ? 0 : 3);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_zero_exponent();
    test_run(4'b0101, SKIP ? 10 : 12, SKIP ? 2 : 3);
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_op();
    test_op_done_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
